// File: rtl/mp_pkg.sv
// Shared constants and helpers for the multiprocessor result path.
// Flag bit positions follow the core ALU flag word {Z,N,C,V}.
package mp_pkg;

  localparam int FLAG_W_DEF = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit width able to index n items, never below 1 so single-item ids stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mp_sync_fifo.sv
// Single-clock FIFO with registered storage; dout is the head entry read straight from storage.
// Push while full and pop while empty are ignored.
module mp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mp_result_collector.sv
// N-core result collector: round-robin grant over per-core valid/ready, core-id tagged FIFO,
// and sticky OR of all accepted flags.
module mp_result_collector
  import mp_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 8,
  parameter int FLAG_W    = FLAG_W_DEF,
  parameter int DEPTH     = 8,
  localparam int ID_W     = clog2_min1(NUM_CORES),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        in_valid,
  output logic [NUM_CORES-1:0]        in_ready,
  input  logic [NUM_CORES*DATA_W-1:0] in_result,
  input  logic [NUM_CORES*FLAG_W-1:0] in_flags,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_result,
  output logic [FLAG_W-1:0]           out_flags,
  output logic [ID_W-1:0]             out_core_id,
  input  logic                        clear_sticky,
  output logic [FLAG_W-1:0]           sticky_flags,
  output logic [CNT_W-1:0]            count
);

  localparam int EW = ID_W + DATA_W + FLAG_W;

  logic [NUM_CORES-1:0][DATA_W-1:0] res_a;
  logic [NUM_CORES-1:0][FLAG_W-1:0] flg_a;
  logic [ID_W-1:0]                  rr_ptr, gnt_id;
  logic [ID_W:0]                    idx_w;
  logic [ID_W-1:0]                  idx;
  logic                             gnt_any, full, empty, accept;
  logic [EW-1:0]                    din, dout;

  assign res_a = in_result;
  assign flg_a = in_flags;

  // First valid core at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx_w   = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx_w = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(NUM_CORES)) idx_w = idx_w - (ID_W+1)'(NUM_CORES);
      idx = idx_w[ID_W-1:0];
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // Reset term keeps in_ready low while reset is held, even though count already reads 0.
  assign accept = reset & ~full & gnt_any;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_rdy
    assign in_ready[i] = accept & (gnt_id == ID_W'(i));
  end

  assign din = {gnt_id, res_a[gnt_id], flg_a[gnt_id]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_CORES - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // A clear coinciding with an accept keeps the new word's flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_flags <= '0;
    end else if (accept) begin
      sticky_flags <= clear_sticky ? flg_a[gnt_id] : (sticky_flags | flg_a[gnt_id]);
    end else if (clear_sticky) begin
      sticky_flags <= '0;
    end
  end

  mp_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (din),
    .pop   (out_ready & ~empty),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid                            = ~empty;
  assign {out_core_id, out_result, out_flags} = dout;

endmodule
